ex_sequencer: RTL
=================

# ex_sequencer

Issue and writeback sequencer for the V850 execute stage. It accepts decoded operations from decode over a valid/ready handshake, and tracks destination-register, second-destination and PSW-flag hazards in a scoreboard. Single-cycle ops stream back-to-back into the execute unit; multi-cycle MUL and DIV are serialised. Writeback strobes are emitted aligned with the execute unit's registered results.

## Interface
Parameters:
- EX_LAT, 2: cycles from issue_valid_o to result for single-cycle ops (input register plus output register).
- MUL_LAT, 3: issue-to-result cycles for MUL/MULH.
- DIV_LAT, 34: issue-to-result cycles for DIV.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, synchronous, active-low.
- dec_valid_i  in  1  decode presents an op.
- dec_ready_o  out  1  combinational; the op is accepted on an edge where valid && ready.
- circuit_sel_i  in  10  execute circuit select.
- destination_i  in  5  primary destination; 0 = none.
- destination2_i  in  5  second destination (DIV remainder, MUL high word); 0 = none.
- src1_i, src2_i  in  5 each  source registers; 0 = none.
- src_psw_i  in  1  op reads PSW (Bcond, CMOV, ADF).
- wr_psw_i  in  1  op writes PSW.
- issue_valid_o  out  1  registered one-cycle strobe to the execute unit.
- circuit_sel_o  out  10  registered; held stable when not issuing.
- wb_valid_o  out  1  result valid this cycle.
- wb_dest_o  out  5  writeback register.
- wb_dest2_valid_o  out  1  second result valid this cycle.
- wb_dest2_o  out  5  second writeback register.
- busy_o  out  1  asserted while anything is in flight.

## Operation
- Op class is decoded from circuit_sel_i:
  - 10'b00_1000_0000 is MUL.
  - 10'b00_0000_1000 is DIV.
  - Everything else is SINGLE.
- Scoreboard: 32-bit pending mask; r0 is never set.
  - On accept, the mask bits for non-zero destination_i and destination2_i are set.
  - Each bit clears at the end of the cycle in which its wb strobe is high.
- psw_pend: counter, incremented on accept when wr_psw_i is high, decremented on a wb whose op wrote PSW. Simultaneous increment and decrement leave it unchanged.
- dec_ready_o is low if any of the following holds:
  - rst_n is low.
  - state is MULTI.
  - a non-zero src1_i, src2_i, destination_i or destination2_i is pending (RAW/WAW).
  - src_psw_i && psw_pend != 0.
  - the class is MUL/DIV and the single pipeline is not empty.
- States:
  - RUN: SINGLE accept pushes {dest, dest2, wr_psw} into an EX_LAT-deep valid shift line. MUL/DIV accept loads cnt = LAT-1 and moves to MULTI.
  - MULTI: cnt decrements each cycle. In the cycle with cnt == 0, wb is emitted with both destinations and the state returns to RUN. Result order is therefore always program order.
- wb_dest2_valid_o is high only when the retiring op has a non-zero destination2.
- wb_valid_o is high for every retiring op, including dest 0 (CMP), so PSW retirement is visible.

## Timing
- Accept on edge N → issue_valid_o and circuit_sel_o are valid in cycle N+1.
- wb_valid_o goes high exactly LAT cycles after the issue_valid_o cycle.
- A dependent op can be accepted in the cycle after its producer's wb cycle at the earliest.
- Maximum SINGLE throughput is one op per cycle.
- busy_o = shift line non-empty || state == MULTI || issue_valid_o.
- Reset (also mid-DIV):
  - all outputs return to 0.
  - mask cleared, psw_pend = 0, state RUN, shift line cleared.
  - in-flight ops produce no wb.
- Counter widths use $clog2(DIV_LAT+1); psw_pend is 3 bits wide and saturates at EX_LAT+1.

## Structure
- Shared package ex_pkg holds:
  - CSEL_MUL and CSEL_DIV constants.
  - the op_class_e enum {SINGLE, MUL, DIV}.
  - the state_e enum {RUN, MULTI}.
  - the latency defaults.
- Sub-module ex_scoreboard holds the pending mask, with set0/set1/clr0/clr1 ports and two hazard-lookup ports.

## Test plan
- Three independent ADDs (r1, r2, r3) on consecutive cycles → issue_valid_o high 3 cycles; wb_dest_o = 1, 2, 3 on cycles issue+2.
- ADD r3 then AND r4←r3 → dec_ready_o low until the cycle after wb_dest_o = 3; AND wb 3 cycles later.
- DIV dest r5, dest2 r6 → busy for 34 cycles; wb_valid_o and wb_dest2_valid_o high together with 5 and 6; a following SUB is held until then.
- ADD r1 in flight, then MUL → MUL accepted only after the ADD wb; MUL wb exactly 3 cycles after its issue.
- CMP (wr_psw) then CMOV (src_psw) → CMOV stalls until the CMP wb (dest 0); psw_pend returns to 0.
- rst_n low for 1 cycle at DIV cnt = 10 → no wb emitted, mask empty, dec_ready_o high the next cycle.

Source files
------------

// File: rtl/ex_pkg.sv
// ex_pkg: shared types and constants for the execute-stage sequencer.
// Holds circuit-select codes, op-class/state enums, latency defaults.
package ex_pkg;

  localparam int EX_LAT_DEF  = 2;
  localparam int MUL_LAT_DEF = 3;
  localparam int DIV_LAT_DEF = 34;

  localparam logic [9:0] CSEL_MUL = 10'b00_1000_0000;
  localparam logic [9:0] CSEL_DIV = 10'b00_0000_1000;

  typedef enum logic [1:0] {
    SINGLE,
    MUL,
    DIV
  } op_class_e;

  typedef enum logic {
    RUN,
    MULTI
  } state_e;

  // One in-flight op as tracked for writeback.
  typedef struct packed {
    logic       v;
    logic [4:0] d;
    logic [4:0] d2;
    logic       psw;
  } ent_t;

  function automatic op_class_e op_class(
    input logic [9:0] csel
  );
    op_class_e c;
    unique case (1'b1)
      (csel == CSEL_MUL): c = MUL;
      (csel == CSEL_DIV): c = DIV;
      default:            c = SINGLE;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/ex_scoreboard.sv
// ex_scoreboard: 32-entry pending-register mask (r0 never pending).
// Ports: two set indices, two clear indices, two paired hazard lookups.
module ex_scoreboard (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       set_en_i,
  input  logic [4:0] set0_i,
  input  logic [4:0] set1_i,
  input  logic       clr_en_i,
  input  logic [4:0] clr0_i,
  input  logic [4:0] clr1_i,
  input  logic [4:0] look_a0_i,
  input  logic [4:0] look_a1_i,
  output logic       hit_a_o,
  input  logic [4:0] look_b0_i,
  input  logic [4:0] look_b1_i,
  output logic       hit_b_o
);

  logic [31:0] mask_q;
  logic [31:0] mask_d;

  // Set wins over clear; the issue logic never lets both
  // target the same register in one cycle anyway.
  always_comb begin
    mask_d = mask_q;
    if (clr_en_i) begin
      mask_d[clr0_i] = 1'b0;
      mask_d[clr1_i] = 1'b0;
    end
    if (set_en_i) begin
      mask_d[set0_i] = 1'b1;
      mask_d[set1_i] = 1'b1;
    end
    mask_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mask_q <= '0;
    end else begin
      mask_q <= mask_d;
    end
  end

  // Bit 0 is always clear, so index 0 ("none") never hits.
  assign hit_a_o = mask_q[look_a0_i]
                 | mask_q[look_a1_i];
  assign hit_b_o = mask_q[look_b0_i]
                 | mask_q[look_b1_i];

endmodule

// File: rtl/ex_sequencer.sv
// ex_sequencer: issue/writeback sequencer for the execute stage.
// Ports: decode handshake in, issue strobe/csel out, wb strobes, busy.
module ex_sequencer
  import ex_pkg::*;
#(
  parameter int EX_LAT  = EX_LAT_DEF,
  parameter int MUL_LAT = MUL_LAT_DEF,
  parameter int DIV_LAT = DIV_LAT_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       dec_valid_i,
  output logic       dec_ready_o,
  input  logic [9:0] circuit_sel_i,
  input  logic [4:0] destination_i,
  input  logic [4:0] destination2_i,
  input  logic [4:0] src1_i,
  input  logic [4:0] src2_i,
  input  logic       src_psw_i,
  input  logic       wr_psw_i,
  output logic       issue_valid_o,
  output logic [9:0] circuit_sel_o,
  output logic       wb_valid_o,
  output logic [4:0] wb_dest_o,
  output logic       wb_dest2_valid_o,
  output logic [4:0] wb_dest2_o,
  output logic       busy_o
);

  localparam int CW = $clog2(DIV_LAT + 1);
  localparam logic [2:0] PSW_MAX = 3'(EX_LAT + 1);

  op_class_e     cls;
  ent_t          ent_in;
  state_e        state_q;
  logic [CW-1:0] cnt_q;
  ent_t          sl_q [EX_LAT];
  ent_t          mop_q;
  ent_t          sl_last;

  logic       issue_q;
  logic [9:0] csel_q;
  logic       wb_v_q;
  logic [4:0] wb_d_q;
  logic       wb_d2v_q;
  logic [4:0] wb_d2_q;
  logic       wb_psw_q;

  logic [2:0] psw_pend_q;
  logic [2:0] psw_pend_d;

  logic sl_busy;
  logic src_hit;
  logic dst_hit;
  logic psw_haz;
  logic multi_blk;
  logic accept;
  logic psw_inc;
  logic psw_dec;

  assign cls = op_class(circuit_sel_i);

  assign ent_in = '{
    v:   1'b1,
    d:   destination_i,
    d2:  destination2_i,
    psw: wr_psw_i
  };

  assign sl_last = sl_q[EX_LAT-1];

  always_comb begin
    sl_busy = 1'b0;
    for (int i = 0; i < EX_LAT; i++) begin
      sl_busy = sl_busy | sl_q[i].v;
    end
  end

  ex_scoreboard u_sb (
    .clk       (clk),
    .rst_n     (rst_n),
    .set_en_i  (accept),
    .set0_i    (destination_i),
    .set1_i    (destination2_i),
    .clr_en_i  (wb_v_q),
    .clr0_i    (wb_d_q),
    .clr1_i    (wb_d2_q),
    .look_a0_i (src1_i),
    .look_a1_i (src2_i),
    .hit_a_o   (src_hit),
    .look_b0_i (destination_i),
    .look_b1_i (destination2_i),
    .hit_b_o   (dst_hit)
  );

  assign psw_haz = src_psw_i
                 && (psw_pend_q != '0);

  // Multi-cycle ops wait for the single line to drain
  // so results always retire in program order.
  assign multi_blk = (cls != SINGLE)
                   && sl_busy;

  assign dec_ready_o = rst_n
                     && (state_q == RUN)
                     && !src_hit
                     && !dst_hit
                     && !psw_haz
                     && !multi_blk;

  assign accept = dec_valid_i
                && dec_ready_o;

  assign psw_inc = accept && wr_psw_i;
  assign psw_dec = wb_v_q && wb_psw_q;

  always_comb begin
    psw_pend_d = psw_pend_q;
    unique case ({psw_inc, psw_dec})
      2'b10: begin
        if (psw_pend_q != PSW_MAX) begin
          psw_pend_d = psw_pend_q + 3'd1;
        end
      end
      2'b01: begin
        if (psw_pend_q != '0) begin
          psw_pend_d = psw_pend_q - 3'd1;
        end
      end
      default: psw_pend_d = psw_pend_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= RUN;
      cnt_q      <= '0;
      mop_q      <= '0;
      issue_q    <= 1'b0;
      csel_q     <= '0;
      wb_v_q     <= 1'b0;
      wb_d_q     <= '0;
      wb_d2v_q   <= 1'b0;
      wb_d2_q    <= '0;
      wb_psw_q   <= 1'b0;
      psw_pend_q <= '0;
      for (int i = 0; i < EX_LAT; i++) begin
        sl_q[i] <= '0;
      end
    end else begin
      issue_q    <= accept;
      psw_pend_q <= psw_pend_d;
      if (accept) begin
        csel_q <= circuit_sel_i;
      end

      sl_q[0] <= '0;
      if (accept && (cls == SINGLE)) begin
        sl_q[0] <= ent_in;
      end
      for (int i = 1; i < EX_LAT; i++) begin
        sl_q[i] <= sl_q[i-1];
      end

      // Default writeback comes off the end of the line;
      // an empty slot carries zeros.
      wb_v_q   <= sl_last.v;
      wb_d_q   <= sl_last.d;
      wb_d2v_q <= sl_last.v && (sl_last.d2 != '0);
      wb_d2_q  <= sl_last.d2;
      wb_psw_q <= sl_last.psw;

      unique case (state_q)
        RUN: begin
          if (accept && (cls != SINGLE)) begin
            state_q <= MULTI;
            mop_q   <= ent_in;
            if (cls == MUL) begin
              cnt_q <= CW'(MUL_LAT - 1);
            end else begin
              cnt_q <= CW'(DIV_LAT - 1);
            end
          end
        end
        MULTI: begin
          if (cnt_q == '0) begin
            // Line is empty here, so this cannot
            // collide with a single-cycle result.
            state_q  <= RUN;
            wb_v_q   <= mop_q.v;
            wb_d_q   <= mop_q.d;
            wb_d2v_q <= mop_q.d2 != '0;
            wb_d2_q  <= mop_q.d2;
            wb_psw_q <= mop_q.psw;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        default: state_q <= RUN;
      endcase
    end
  end

  assign issue_valid_o    = issue_q;
  assign circuit_sel_o    = csel_q;
  assign wb_valid_o       = wb_v_q;
  assign wb_dest_o        = wb_d_q;
  assign wb_dest2_valid_o = wb_d2v_q;
  assign wb_dest2_o       = wb_d2_q;

  assign busy_o = sl_busy
                || (state_q == MULTI)
                || issue_q;

endmodule
